score_display_mux: RTL and testbench

Parametrised score tracker and display driver. It counts good/bad collision events into a binary score and keeps a session high score. A sequential double-dabble converter produces NUM_DIGITS BCD digits, which are time-multiplexed onto one shared 7-segment bus with leading-zero blanking and game-over blinking. Sits between the game-logic collision outputs and the board's seven-segment pins.

---
 rtl/score_display_mux.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_score_display_mux.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_display_mux.sv
// Score/high-score tracker with sequential binary-to-BCD conversion
// and a multiplexed, blanking, blinking seven-segment driver.
module score_display_mux #(
    parameter int NUM_DIGITS = 3,
    parameter int SCORE_W    = 10,
    parameter int MAX_SCORE  = 999,
    parameter int SCAN_DIV   = 4,
    parameter int BLINK_DIV  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  good_coll,
    input  logic                  bad_coll,
    input  logic                  new_game,
    input  logic                  blank_lz,
    output logic [SCORE_W-1:0]    score,
    output logic [SCORE_W-1:0]    high_score,
    output logic                  game_over,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic [6:0]            seg
);

    localparam int BCD_W   = 4 * NUM_DIGITS;
    localparam int CNT_W   = $clog2(SCORE_W + 1);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam longint MAX_DISP = longint'(10 ** NUM_DIGITS) - 1;
    localparam longint MAX_BIN  = longint'(1) << SCORE_W;

    localparam logic [SCORE_W-1:0] MAX_V    = SCORE_W'(MAX_SCORE);
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(SCORE_W - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SCAN_W-1:0]  LAST_SCN = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] LAST_BLK = BLINK_W'(BLINK_DIV - 1);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 4) begin : g_bad_digits
        $error("NUM_DIGITS must be 1..4");
    end
    if (longint'(MAX_SCORE) > MAX_DISP) begin : g_bad_max_disp
        $error("MAX_SCORE does not fit in NUM_DIGITS digits");
    end
    if (longint'(MAX_SCORE) >= MAX_BIN) begin : g_bad_max_bin
        $error("MAX_SCORE does not fit in SCORE_W bits");
    end
    if (SCAN_DIV < 1 || BLINK_DIV < 1) begin : g_bad_div
        $error("SCAN_DIV and BLINK_DIV must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_COMMIT
    } conv_state_t;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] p;
        p = 7'b0000000;
        case (d)
            4'd0:    p = 7'b0111111;
            4'd1:    p = 7'b0000110;
            4'd2:    p = 7'b1011011;
            4'd3:    p = 7'b1001111;
            4'd4:    p = 7'b1100110;
            4'd5:    p = 7'b1101101;
            4'd6:    p = 7'b1111101;
            4'd7:    p = 7'b0000111;
            4'd8:    p = 7'b1111111;
            4'd9:    p = 7'b1100111;
            default: p = 7'b0000000;
        endcase
        return p;
    endfunction

    logic [SCORE_W-1:0] score_inc;
    logic [SCORE_W-1:0] disp_val;

    assign score_inc = score + 1'b1;
    assign disp_val  = game_over ? high_score : score;

    // new_game > bad_coll > good_coll; collisions are dead while game over
    always_ff @(posedge clk) begin
        if (rst) begin
            score      <= '0;
            high_score <= '0;
            game_over  <= 1'b0;
        end else if (new_game) begin
            score     <= '0;
            game_over <= 1'b0;
        end else if (!game_over) begin
            if (bad_coll) begin
                game_over <= 1'b1;
            end else if (good_coll) begin
                score <= score_inc;
                if (score_inc > high_score) begin
                    high_score <= score_inc;
                end
                if (score_inc == MAX_V) begin
                    game_over <= 1'b1;
                end
            end
        end
    end

    conv_state_t        state;
    conv_state_t        state_nxt;
    logic [SCORE_W-1:0] bin_sh;
    logic [SCORE_W-1:0] cap_val;
    logic [SCORE_W-1:0] last_val;
    logic [BCD_W-1:0]   bcd;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   digits;
    logic [CNT_W-1:0]   bit_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (disp_val != last_val) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (bit_cnt == LAST_BIT) begin
                    state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // digits only change on COMMIT, so a half-done pass is never shown
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_sh   <= '0;
            cap_val  <= '0;
            last_val <= '0;
            bcd      <= '0;
            digits   <= '0;
            bit_cnt  <= '0;
        end else begin
            unique case (state)
                S_LOAD: begin
                    bin_sh  <= disp_val;
                    cap_val <= disp_val;
                    bcd     <= '0;
                    bit_cnt <= '0;
                end
                S_SHIFT: begin
                    {bcd, bin_sh} <= {bcd_adj, bin_sh} << 1;
                    bit_cnt       <= bit_cnt + 1'b1;
                end
                S_COMMIT: begin
                    digits   <= bcd;
                    last_val <= cap_val;
                end
                default: begin
                end
            endcase
        end
    end

    logic [SCAN_W-1:0]  scan_cnt;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_nxt;
    logic               scan_tick;
    logic               frame_end;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_tick;
    logic               phase;
    logic               phase_nxt;

    assign scan_tick  = (scan_cnt == LAST_SCN);
    assign frame_end  = scan_tick && (idx == LAST_IDX);
    assign blink_tick = frame_end && (blink_cnt == LAST_BLK);

    always_comb begin
        idx_nxt = idx;
        if (scan_tick) begin
            idx_nxt = (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

    always_comb begin
        phase_nxt = phase;
        if (!game_over) begin
            phase_nxt = 1'b1;
        end else if (blink_tick) begin
            phase_nxt = ~phase;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else begin
            scan_cnt <= scan_tick ? '0 : scan_cnt + 1'b1;
            idx      <= idx_nxt;
        end
    end

    // held at on/0 while playing, so the rising edge of game_over restarts it
    always_ff @(posedge clk) begin
        if (rst || !game_over) begin
            blink_cnt <= '0;
        end else if (frame_end) begin
            blink_cnt <= blink_tick ? '0 : blink_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= 1'b1;
        end else begin
            phase <= phase_nxt;
        end
    end

    logic [NUM_DIGITS-1:0] blank_vec;
    logic                  zero_run;
    logic [3:0]            cur_digit;
    logic                  cur_blank;
    logic [NUM_DIGITS-1:0] digit_sel_nxt;
    logic [6:0]            seg_nxt;

    always_comb begin
        zero_run  = 1'b1;
        blank_vec = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run && (digits[4*i +: 4] == 4'd0);
            blank_vec[i] = zero_run && (i != 0);
        end
    end

    always_comb begin
        cur_digit     = '0;
        cur_blank     = 1'b0;
        digit_sel_nxt = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_nxt == IDX_W'(i)) begin
                cur_digit        = digits[4*i +: 4];
                cur_blank        = blank_vec[i];
                digit_sel_nxt[i] = 1'b1;
            end
        end
        seg_nxt = decode(cur_digit);
        if (!phase_nxt || (blank_lz && cur_blank)) begin
            seg_nxt = 7'b0000000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_sel <= NUM_DIGITS'(1);
            seg       <= 7'b0000000;
        end else begin
            digit_sel <= digit_sel_nxt;
            seg       <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_score_display_mux.sv
// Scoreboard bench for score_display_mux: counting, game over,
// max score, scan order, blanking, blinking and reset mid-conversion.
module tb_score_display_mux;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       good_coll = 1'b0;
    logic       bad_coll = 1'b0;
    logic       new_game = 1'b0;
    logic       blank_lz = 1'b0;
    logic [9:0] score, high_score, score12, high12;
    logic       game_over, go12;
    logic [2:0] digit_sel, sel12;
    logic [6:0] seg, seg12;

    int n_checks = 0;
    int n_pass = 0;
    int          exp_q[$];
    logic [20:0] frame_q[$];

    always #5 clk = ~clk;

    score_display_mux dut (
        .clk(clk), .rst(rst), .good_coll(good_coll),
        .bad_coll(bad_coll), .new_game(new_game),
        .blank_lz(blank_lz), .score(score),
        .high_score(high_score), .game_over(game_over),
        .digit_sel(digit_sel), .seg(seg)
    );

    score_display_mux #(.MAX_SCORE(12)) dut12 (
        .clk(clk), .rst(rst), .good_coll(good_coll),
        .bad_coll(bad_coll), .new_game(new_game),
        .blank_lz(blank_lz), .score(score12),
        .high_score(high12), .game_over(go12),
        .digit_sel(sel12), .seg(seg12)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1100111;
            default: return 7'b0000000;
        endcase
    endfunction

    // digit i (i>0) is a leading zero exactly when v < 10^i
    function automatic logic [20:0] exp_frame(input int v, input bit blz);
        logic [20:0] f;
        int p;
        int d;
        f = '0;
        p = 1;
        for (int i = 0; i < 3; i++) begin
            d = (v / p) % 10;
            if (blz && i > 0 && v < p) f[7*i +: 7] = 7'b0000000;
            else f[7*i +: 7] = pat(d);
            p = p * 10;
        end
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic good_pulse();
        good_coll = 1'b1;
        tick();
        good_coll = 1'b0;
    endtask

    task automatic capture_frame(output logic [20:0] f);
        f = 'x;
        for (int c = 0; c < 12; c++) begin
            tick();
            case (digit_sel)
                3'b001: f[6:0]   = seg;
                3'b010: f[13:7]  = seg;
                3'b100: f[20:14] = seg;
                default: f = 'x;
            endcase
        end
    endtask

    task automatic test_reset();
        logic [20:0] f, e;
        logic [2:0]  es;
        rst = 1'b1;
        blank_lz = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if ({score, high_score, game_over, digit_sel, seg} !==
            {10'd0, 10'd0, 1'b0, 3'b001, 7'd0}) begin
            $display("FAIL reset_state got %h %h %b %b %b want 0 0 0 001 0",
                     score, high_score, game_over, digit_sel, seg);
        end else n_pass++;
        for (int k = 1; k <= 20; k++) begin
            tick();
            es = 3'b001 << ((k / 4) % 3);
            n_checks++;
            if (digit_sel !== es) begin
                $display("FAIL scan_sel k=%0d got %b want %b", k, digit_sel, es);
            end else n_pass++;
            n_checks++;
            if (seg !== 7'b0111111) begin
                $display("FAIL scan_seg k=%0d got %b want 0111111", k, seg);
            end else n_pass++;
        end
        blank_lz = 1'b1;
        tick();
        frame_q.push_back(exp_frame(0, 1'b1));
        capture_frame(f);
        e = frame_q.pop_front();
        n_checks++;
        if (f !== e) $display("FAIL frame_blank0 got %b want %b", f, e);
        else n_pass++;
    endtask

    task automatic test_count();
        logic [20:0] f, e;
        int x;
        for (int i = 1; i <= 12; i++) begin
            good_pulse();
            exp_q.push_back(i);
            x = exp_q.pop_front();
            n_checks++;
            if (score !== 10'(x)) $display("FAIL count got %0d want %0d", score, x);
            else n_pass++;
        end
        n_checks++;
        if (high_score !== 10'd12) $display("FAIL high12 got %0d want 12", high_score);
        else n_pass++;
        repeat (30) tick();
        frame_q.push_back(exp_frame(12, 1'b1));
        capture_frame(f);
        e = frame_q.pop_front();
        n_checks++;
        if (f !== e) $display("FAIL frame_12 got %b want %b", f, e);
        else n_pass++;
        good_pulse();
        frame_q.push_back(exp_frame(13, 1'b1));
        repeat (16) tick();
        capture_frame(f);
        e = frame_q.pop_front();
        n_checks++;
        if (f !== e) $display("FAIL frame_13_latency got %b want %b", f, e);
        else n_pass++;
    endtask

    task automatic test_simul();
        int t[$];
        bit have_prev, prev, lit;
        int x;
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        n_checks++;
        if (score !== 10'd0 || game_over !== 1'b0 || high_score !== 10'd13) begin
            $display("FAIL new_game got %0d %b %0d want 0 0 13", score, game_over, high_score);
        end else n_pass++;
        for (int i = 1; i <= 5; i++) begin
            good_pulse();
            exp_q.push_back(i);
        end
        x = exp_q.pop_back();
        exp_q.delete();
        n_checks++;
        if (score !== 10'(x)) $display("FAIL count5 got %0d want %0d", score, x);
        else n_pass++;
        good_coll = 1'b1;
        bad_coll = 1'b1;
        tick();
        good_coll = 1'b0;
        bad_coll = 1'b0;
        n_checks++;
        if (score !== 10'd5 || game_over !== 1'b1) begin
            $display("FAIL simul_coll got %0d %b want 5 1", score, game_over);
        end else n_pass++;
        good_pulse();
        n_checks++;
        if (score !== 10'd5) $display("FAIL ignore_good got %0d want 5", score);
        else n_pass++;
        have_prev = 1'b0;
        prev = 1'b0;
        for (int c = 0; c < 400 && t.size() < 3; c++) begin
            tick();
            if (digit_sel === 3'b001) begin
                lit = (seg !== 7'd0);
                if (have_prev && lit != prev) t.push_back(c);
                prev = lit;
                have_prev = 1'b1;
            end
        end
        n_checks++;
        if (t.size() < 3) begin
            $display("FAIL blink_timeout got %0d toggles want 3", t.size());
        end else begin
            n_pass++;
            n_checks++;
            if (t[1] - t[0] != 96) $display("FAIL blink_period1 got %0d want 96", t[1] - t[0]);
            else n_pass++;
            n_checks++;
            if (t[2] - t[1] != 96) $display("FAIL blink_period2 got %0d want 96", t[2] - t[1]);
            else n_pass++;
        end
    endtask

    task automatic test_new_game();
        logic [20:0] f, e;
        int x;
        bit seen_off;
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            good_pulse();
            exp_q.push_back(i);
            x = exp_q.pop_front();
            n_checks++;
            if (score !== 10'(x)) $display("FAIL ng_count got %0d want %0d", score, x);
            else n_pass++;
        end
        n_checks++;
        if (high_score !== 10'd13) $display("FAIL ng_high got %0d want 13", high_score);
        else n_pass++;
        repeat (30) tick();
        frame_q.push_back(exp_frame(3, 1'b1));
        capture_frame(f);
        e = frame_q.pop_front();
        n_checks++;
        if (f !== e) $display("FAIL frame_3 got %b want %b", f, e);
        else n_pass++;
        bad_coll = 1'b1;
        tick();
        bad_coll = 1'b0;
        n_checks++;
        if (game_over !== 1'b1 || score !== 10'd3) begin
            $display("FAIL ng_over got %b %0d want 1 3", game_over, score);
        end else n_pass++;
        frame_q.push_back(exp_frame(13, 1'b1));
        repeat (20) tick();
        capture_frame(f);
        e = frame_q.pop_front();
        n_checks++;
        if (f !== e) $display("FAIL frame_high got %b want %b", f, e);
        else n_pass++;
        seen_off = 1'b0;
        for (int c = 0; c < 150 && !seen_off; c++) begin
            tick();
            if (digit_sel === 3'b001 && seg === 7'd0) seen_off = 1'b1;
        end
        n_checks++;
        if (!seen_off) $display("FAIL high_blink got lit want blank phase");
        else n_pass++;
    endtask

    task automatic test_max();
        int x;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            good_pulse();
            exp_q.push_back(i);
            x = exp_q.pop_front();
            n_checks++;
            if (score12 !== 10'(x) || go12 !== (i == 12)) begin
                $display("FAIL max_count i=%0d got %0d %b want %0d %b",
                         i, score12, go12, x, (i == 12));
            end else n_pass++;
        end
        good_pulse();
        n_checks++;
        if (score12 !== 10'd12 || go12 !== 1'b1) begin
            $display("FAIL max_sat got %0d %b want 12 1", score12, go12);
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [20:0] f, e;
        good_pulse();
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({score, high_score, game_over, digit_sel, seg} !==
            {10'd0, 10'd0, 1'b0, 3'b001, 7'd0}) begin
            $display("FAIL reset_mid got %h %h %b %b %b want 0 0 0 001 0",
                     score, high_score, game_over, digit_sel, seg);
        end else n_pass++;
        good_pulse();
        frame_q.push_back(exp_frame(1, 1'b1));
        repeat (20) tick();
        capture_frame(f);
        e = frame_q.pop_front();
        n_checks++;
        if (f !== e) $display("FAIL frame_after_rst got %b want %b", f, e);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_count();
        test_simul();
        test_new_game();
        test_max();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
